add_mul_stream_adapter: RTL and testbench

//  Valid/ready wrapper around the fixed-latency, non-stallable add_mul pipeline ((x+y)*z mod 2^32).

---
 rtl/add_mul_stream_pkg.sv | 15 +
 rtl/add_mul_result_fifo.sv | 65 ++++++
 rtl/add_mul_stream_adapter.sv | 84 ++++++++
 tb/tb_add_mul_stream_adapter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_mul_stream_pkg.sv
// Shared types and constants for the add_mul valid/ready stream adapter.
package add_mul_stream_pkg;

    localparam int WORD_W          = 32;
    localparam int ADD_MUL_LATENCY = 3;

    typedef logic [WORD_W-1:0] add_mul_word_t;

    typedef struct packed {
        add_mul_word_t x;
        add_mul_word_t y;
        add_mul_word_t z;
    } add_mul_operands_t;

endpackage

// File: rtl/add_mul_result_fifo.sv
// In-order result FIFO for the add_mul adapter.
// Pointers carry one extra wrap bit so full and empty are told apart by the MSB.
// DEPTH must be a power of two and at least 2.
// The head reads as zero whenever the FIFO is empty.
module add_mul_result_fifo
    import add_mul_stream_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer independently so a push and a pop in the same cycle both take effect.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; reset empties the FIFO and discards whatever it held.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/add_mul_stream_adapter.sv
// Valid/ready wrapper around the fixed-latency, non-stallable add_mul pipeline.
// A valid shift register follows each issued triple through add_mul.
// Credits cover both in-flight and queued results, so every result always has a FIFO slot.
module add_mul_stream_adapter
    import add_mul_stream_pkg::*;
#(
    parameter int WIDTH   = WORD_W,
    parameter int LATENCY = ADD_MUL_LATENCY,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic [WIDTH-1:0] pipe_x,
    output logic [WIDTH-1:0] pipe_y,
    output logic [WIDTH-1:0] pipe_z,
    input  logic [WIDTH-1:0] pipe_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  CREDITS = CW'(DEPTH);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CW-1:0]      used_q, used_d;
    logic               fire, pop;
    logic               fifo_full, fifo_empty;

    assign pipe_x = in_x;
    assign pipe_y = in_y;
    assign pipe_z = in_z;

    // in_ready depends only on the credit register, never on out_ready.
    assign in_ready  = !rst && (used_q < CREDITS);
    assign fire      = in_valid && in_ready;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    // Shift validity alongside add_mul and update credits: fire takes one, pop returns one.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = fire;
        used_d   = used_q + {{(CW-1){1'b0}}, fire} - {{(CW-1){1'b0}}, pop};
    end

    // State registers; reset drops in-flight results by clearing validity.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            used_q <= '0;
        end else begin
            vld_q  <= vld_d;
            used_q <= used_d;
        end
    end

    // The credit scheme guarantees a free slot for every result leaving add_mul.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(vld_q[LATENCY-1] && fifo_full));
        end
    end

    add_mul_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_result_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (vld_q[LATENCY-1]),
        .push_data (pipe_out),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

endmodule

// File: tb/tb_add_mul_stream_adapter.sv
// Self-checking bench for add_mul_stream_adapter.
// It includes a behavioural add_mul stand-in and a queue-based reference model.
module tb_add_mul_stream_adapter;
    import add_mul_stream_pkg::*;

    localparam int DEPTH = 8;
    localparam int LAT   = ADD_MUL_LATENCY;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    add_mul_word_t in_x = '0, in_y = '0, in_z = '0;
    logic          in_ready, out_valid;
    add_mul_word_t pipe_x, pipe_y, pipe_z, pipe_out, out_data;

    add_mul_stream_adapter #(.WIDTH(WORD_W), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_z      (in_z),
        .pipe_x    (pipe_x),
        .pipe_y    (pipe_y),
        .pipe_z    (pipe_z),
        .pipe_out  (pipe_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the parent-owned add_mul: three register stages, never stalls.
    add_mul_word_t am_s0, am_s1, am_s2;
    always @(posedge clk) begin
        am_s0 <= (pipe_x + pipe_y) * pipe_z;
        am_s1 <= am_s0;
        am_s2 <= am_s1;
    end
    assign pipe_out = am_s2;

    // Reference model: every accepted triple with the cycle its result may first appear.
    typedef struct {
        add_mul_word_t data;
        int            ready_cyc;
    } pend_t;
    pend_t exp_q[$];

    typedef struct {
        add_mul_operands_t op;
        add_mul_word_t     exp;
    } vec_t;

    int            cyc = 0;
    int            compared = 0;
    int            mismatched = 0;
    logic          smp_valid, smp_ready;
    add_mul_word_t smp_data;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input add_mul_word_t x, input add_mul_word_t y,
                                 input add_mul_word_t z, input logic ordy);
        in_valid  = v;
        in_x      = x;
        in_y      = y;
        in_z      = z;
        out_ready = ordy;
    endtask

    // One clock cycle: sample at negedge, check against the model, advance the model, cross the edge.
    task automatic step();
        logic          avail, m_fire, m_pop;
        add_mul_word_t res;
        @(negedge clk);
        smp_valid = out_valid;
        smp_ready = in_ready;
        smp_data  = out_data;
        avail  = (exp_q.size() > 0) && (exp_q[0].ready_cyc <= cyc);
        m_fire = in_valid && !rst && (exp_q.size() < DEPTH);
        m_pop  = avail && out_ready;
        checkOutput("in_ready", 32'(in_ready), 32'(!rst && (exp_q.size() < DEPTH)));
        checkOutput("out_valid", 32'(out_valid), 32'(avail));
        if (avail) begin
            checkOutput("out_data", out_data, exp_q[0].data);
        end
        if (m_pop) begin
            void'(exp_q.pop_front());
        end
        if (m_fire) begin
            res = (in_x + in_y) * in_z;
            exp_q.push_back('{data: res, ready_cyc: cyc + LAT + 1});
        end
        if (rst) begin
            exp_q.delete();
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    // Fire one triple and wait, with a bound, for its result; check latency, value and drain.
    task automatic runSingle(input add_mul_word_t x, input add_mul_word_t y, input add_mul_word_t z,
                             input add_mul_word_t expv);
        int   fire_cyc, lat;
        logic found;
        add_mul_word_t got;
        applyStimulus(1'b1, x, y, z, 1'b1);
        step();
        fire_cyc = cyc - 1;
        checkOutput("single_accept", 32'(smp_ready), 32'd1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        found = 1'b0;
        lat   = 0;
        got   = '0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (smp_valid) begin
                found = 1'b1;
                lat   = cyc - 1 - fire_cyc;
                got   = smp_data;
            end
        end
        if (!found) begin
            checkOutput("single_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("single_latency", 32'(lat), 32'd4);
            checkOutput("single_result", got, expv);
            step();
            checkOutput("single_drained", 32'(smp_valid), 32'd0);
        end
    endtask

    // Watchdog so the run always ends even if the sequencing wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main test sequence.
    initial begin
        vec_t vecs[8];
        int   lows, npops, first_pop, last_pop, accepted, first_ready, stale;

        vecs[0] = '{op: '{x: 32'd2,          y: 32'd3,          z: 32'd7},       exp: 32'd35};
        vecs[1] = '{op: '{x: 32'hFFFF_FFFF,  y: 32'd1,          z: 32'd5},       exp: 32'd0};
        vecs[2] = '{op: '{x: 32'h0001_0000,  y: 32'd0,          z: 32'h1_0000},  exp: 32'd0};
        vecs[3] = '{op: '{x: 32'd1,          y: 32'd1,          z: 32'd1},       exp: 32'd2};
        vecs[4] = '{op: '{x: 32'h8000_0000,  y: 32'h8000_0000,  z: 32'd3},       exp: 32'd0};
        vecs[5] = '{op: '{x: 32'd10,         y: 32'd20,         z: 32'd16},      exp: 32'd480};
        vecs[6] = '{op: '{x: 32'hFFFF_FFFF,  y: 32'hFFFF_FFFF,  z: 32'd2},       exp: 32'hFFFF_FFFC};
        vecs[7] = '{op: '{x: 32'h0000_1234,  y: 32'h0000_4321,  z: 32'h100},     exp: 32'h0055_5500};

        // Reset state
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        step();
        checkOutput("reset_out_valid", 32'(smp_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(smp_ready), 32'd0);
        checkOutput("reset_out_data", smp_data, 32'd0);
        step();
        rst = 1'b0;
        step();
        checkOutput("post_reset_in_ready", 32'(smp_ready), 32'd1);

        // Table-driven single transactions including mod 2^32 wrap
        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            runSingle(vecs[i].op.x, vecs[i].op.y, vecs[i].op.z, vecs[i].exp);
        end

        // Back-to-back stream at full rate
        $display("[TB] stream");
        resetDut();
        lows = 0; npops = 0; first_pop = -1; last_pop = -1;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, $urandom, 1'b1);
            step();
            if (!smp_ready) lows++;
            if (smp_valid) begin
                npops++;
                if (first_pop < 0) first_pop = cyc - 1;
                last_pop = cyc - 1;
            end
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            if (smp_valid) begin
                npops++;
                if (first_pop < 0) first_pop = cyc - 1;
                last_pop = cyc - 1;
            end
        end
        checkOutput("stream_in_ready_lows", 32'(lows), 32'd0);
        checkOutput("stream_result_count", 32'(npops), 32'd32);
        checkOutput("stream_consecutive", 32'(last_pop - first_pop), 32'd31);

        // Backpressure: credits stop issue at DEPTH
        $display("[TB] backpressure");
        resetDut();
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, $urandom, 1'b0);
            step();
            if (smp_ready) accepted++;
        end
        checkOutput("bp_accepted", 32'(accepted), 32'd8);
        checkOutput("bp_in_ready_low", 32'(smp_ready), 32'd0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        npops = 0; first_pop = -1; first_ready = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (smp_valid) begin
                npops++;
                if (first_pop < 0) first_pop = cyc - 1;
            end
            if (smp_ready && first_ready < 0) first_ready = cyc - 1;
        end
        checkOutput("bp_drain_count", 32'(npops), 32'd8);
        checkOutput("bp_ready_after_pop", 32'(first_ready - first_pop), 32'd1);

        // Random valid/ready traffic against the model
        $display("[TB] random traffic");
        resetDut();
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
            step();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
        end
        checkOutput("rand_drained_valid", 32'(smp_valid), 32'd0);
        checkOutput("rand_drained_ready", 32'(smp_ready), 32'd1);

        // Reset with 3 results in flight and 4 queued
        $display("[TB] reset mid-stream");
        resetDut();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, $urandom, $urandom, $urandom, 1'b0);
            step();
        end
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0);
        step();
        step();
        checkOutput("mid_rst_out_valid", 32'(smp_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, '0, '0, '0, 1'b1);
        step();
        checkOutput("mid_rst_in_ready", 32'(smp_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (smp_valid) stale++;
        end
        checkOutput("mid_rst_no_stale", 32'(stale), 32'd0);
        runSingle(32'd1, 32'd1, 32'd1, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
